// File: rtl/enc_stim_gen.sv
// enc_stim_gen: framed INC/PRBS/CONST word generator for the encoder datapath.
// Beats leave under a valid/ready handshake with sof/eof framing and a done pulse.
module enc_stim_gen #(
  parameter int ENC_SYM     = 4,
  parameter int EGF_DIM     = 4,
  parameter int FRAME_WORDS = 4,
  parameter int GAP_CYCLES  = 0,
  parameter int FRM_W       = 8,
  parameter logic [ENC_SYM*EGF_DIM-1:0] POLY = 16'h1021,
  parameter logic [ENC_SYM*EGF_DIM-1:0] SEED = 16'h0001
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [1:0]                 cfg_mode,
  input  logic [FRM_W-1:0]           cfg_frames,
  input  logic [ENC_SYM*EGF_DIM-1:0] cfg_const,
  input  logic                       gen_ready,
  output logic                       gen_valid,
  output logic [ENC_SYM*EGF_DIM-1:0] gen_data,
  output logic                       gen_sof,
  output logic                       gen_eof,
  output logic                       busy,
  output logic                       done
);

  localparam int W  = ENC_SYM * EGF_DIM;
  localparam int KW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [W-1:0] SEED_NZ = (SEED == '0) ? W'(1) : SEED;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP,
    FIN
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     mode_q;
  logic [FRM_W-1:0] frames_q;
  logic [W-1:0]   const_q;
  logic [W-1:0]   prbs_q;
  logic [W-1:0]   prbs_nxt;
  logic [KW-1:0]  word_q;
  logic [GW-1:0]  gap_q;
  logic [W-1:0]   inc_word;
  logic [W-1:0]   data;
  logic           accept;
  logic           last_word;
  logic           last_frame;
  logic           gap_done;
  logic           start_ok;

  assign accept     = (state_q == RUN) && gen_ready;
  assign last_word  = (word_q == KW'(FRAME_WORDS - 1));
  assign last_frame = (frames_q == FRM_W'(1));
  assign gap_done   = (gap_q == GW'(GAP_CYCLES - 1));
  assign start_ok   = (state_q == IDLE) && start && !abort;
  assign prbs_nxt   = {prbs_q[W-2:0], 1'b0} ^ (prbs_q[W-1] ? POLY : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // abort overrides every other transition, including an accepted start
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (cfg_frames == '0) ? FIN : RUN;
      RUN: begin
        if (accept && last_word) begin
          if (last_frame) state_d = FIN;
          else state_d = (GAP_CYCLES > 0) ? GAP : RUN;
        end
      end
      GAP: if (gap_done) state_d = RUN;
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= '0;
      frames_q <= '0;
      const_q  <= '0;
      prbs_q   <= SEED_NZ;
      word_q   <= '0;
      gap_q    <= '0;
    end else begin
      if (start_ok) begin
        mode_q   <= cfg_mode;
        frames_q <= cfg_frames;
        const_q  <= cfg_const;
        prbs_q   <= SEED_NZ;
        word_q   <= '0;
      end else if (accept) begin
        prbs_q <= prbs_nxt;
        word_q <= last_word ? '0 : word_q + KW'(1);
        if (last_word) frames_q <= frames_q - FRM_W'(1);
      end
      gap_q <= (state_q == GAP) ? gap_q + GW'(1) : '0;
    end
  end

  // symbol 0 sits in the MSBs
  always_comb begin
    inc_word = '0;
    for (int j = 0; j < ENC_SYM; j++) begin
      inc_word[(ENC_SYM-1-j)*EGF_DIM +: EGF_DIM] =
        EGF_DIM'(int'(word_q) * ENC_SYM + j);
    end
    data = '0;
    unique case (1'b1)
      (mode_q == 2'd1): data = prbs_q;
      (mode_q == 2'd2): data = const_q;
      default:          data = inc_word;
    endcase
  end

  assign gen_valid = (state_q == RUN);
  assign gen_data  = gen_valid ? data : '0;
  assign gen_sof   = gen_valid && (word_q == '0);
  assign gen_eof   = gen_valid && last_word;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);

endmodule
